// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: op codes and controller states.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ANDI = 2'b01;
  localparam logic [1:0] OP_SRAI = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sra_unit.sv
// Arithmetic right shift engine: iterative 1 bit/cycle ACC/CNT, or a barrel shifter
// when ALU_SEQ_BARREL_SHIFT_EN is defined (go_shift never asserts in that build).
module alu_sra_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               go_shift,
  output logic [DATA_W-1:0]  imm_res,
  output logic [DATA_W-1:0]  step_res,
  output logic               last
);

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  logic unused_ok;

  assign go_shift  = 1'b0;
  assign imm_res   = $signed(a) >>> shamt;
  assign step_res  = a;
  assign last      = 1'b1;
  assign unused_ok = ^{clk, rst_n, flush, start};
`else
  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;

  // A zero shift amount completes in the accept cycle with the operand itself.
  assign go_shift = start & (shamt != '0);
  assign imm_res  = a;
  assign step_res = {acc[DATA_W-1], acc[DATA_W-1:1]};
  assign last     = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (go_shift) begin
      acc <= a;
      cnt <= shamt;
    end else if (cnt != '0) begin
      acc <= step_res;
      cnt <= cnt - SHAMT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Execute-stage controller for ADD/ANDI/SRAI/XOR: one op per handshake, result held until taken.
// Optional ALU_SEQ_BARREL_SHIFT_EN makes SRAI single-cycle; otherwise SRAI takes 1+SHAMT cycles.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic               sel_in1,
  output logic               sel_in2,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               busy
);

  state_t            state;
  logic [1:0]        sel;
  logic              accept;
  logic              go_shift;
  logic              last;
  logic [DATA_W-1:0] imm_res;
  logic [DATA_W-1:0] step_res;
  logic [DATA_W-1:0] alu_res;

  // Flush blocks acceptance so an aborted cycle never loads a new op.
  assign req_ready = rst_n & ~flush &
                     ((state == IDLE) | ((state == DONE) & res_ready));
  assign accept    = req_valid & req_ready;
  assign sel_in1   = sel[1];
  assign sel_in2   = sel[0];
  assign busy      = (state != IDLE);

  alu_sra_unit #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_sra (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .start   (accept & (req_op == OP_SRAI)),
    .a       (req_a),
    .shamt   (req_shamt),
    .go_shift(go_shift),
    .imm_res (imm_res),
    .step_res(step_res),
    .last    (last)
  );

  always_comb begin
    alu_res = '0;
    case (req_op)
      OP_ADD:  alu_res = req_a + req_b;
      OP_ANDI: alu_res = req_a & req_b;
      OP_SRAI: alu_res = imm_res;
      OP_XOR:  alu_res = req_a ^ req_b;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'b00;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      sel       <= 2'b00;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sel <= req_op;
            if (go_shift) begin
              state     <= SHIFT;
              res_valid <= 1'b0;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= alu_res;
            end
          end else if ((state == DONE) && res_ready) begin
            state     <= IDLE;
            sel       <= 2'b00;
            res_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (last) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= step_res;
          end
        end
        default: begin
          state     <= IDLE;
          sel       <= 2'b00;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
